bram_port_arbiter: RTL and testbench

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

---
 rtl/bram_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/bram_port_arbiter.sv | 118 +++++++++++
 tb/tb_bram_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared defaults and helpers for the block-RAM port arbiter.
package bram_arb_pkg;

  localparam int unsigned DEF_NREQ   = 4;
  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DATA_W = 18;
  localparam int unsigned DEF_RD_LAT = 2;

  // Requester-id width; a single requester still needs a 1-bit id.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } cmd_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first asserted request at or above ptr, wrapping modulo NREQ.
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned ID_W = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one block-RAM port among NREQ requesters with round-robin grants and
// a non-stalling read-tag pipeline that routes returning data to its requester.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NREQ   = DEF_NREQ,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RD_LAT = DEF_RD_LAT
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [NREQ-1:0]          wr_ack,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_din,
  output logic                     ram_regce,
  output logic                     ram_rst,
  input  logic [DATA_W-1:0]        ram_dout
);

  localparam int unsigned ID_W = id_width(NREQ);

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   gnt_id;
  logic [NREQ-1:0]   grant;
  logic              any_grant;

  logic              en_q;
  cmd_e              kind_q;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;

  logic [RD_LAT-1:0] tag_v;
  logic [ID_W-1:0]   tag_id [RD_LAT];

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    gnt_id = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) gnt_id = ID_W'(i);
    end
  end

  assign req_ready = rstb ? '0 : grant;
  assign any_grant = |req_ready;

  always_ff @(posedge clk) begin
    if (rstb) begin
      ptr <= '0;
    end else if (any_grant) begin
      ptr <= (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Issue register: the granted command drives the RAM port in the next cycle.
  always_ff @(posedge clk) begin
    if (rstb) begin
      en_q   <= 1'b0;
      kind_q <= CMD_RD;
      id_q   <= '0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      en_q <= any_grant;
      if (any_grant) begin
        kind_q <= cmd_e'(req_we[gnt_id]);
        id_q   <= gnt_id;
        addr_q <= req_addr[32'(gnt_id) * ADDR_W +: ADDR_W];
        din_q  <= req_wdata[32'(gnt_id) * DATA_W +: DATA_W];
      end
    end
  end

  // Tag pipeline advances every cycle; stage RD_LAT-1 lines up with ram_dout.
  always_ff @(posedge clk) begin
    if (rstb) begin
      tag_v <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_v[0]  <= en_q && (kind_q == CMD_RD);
      tag_id[0] <= id_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign ram_en    = en_q & ~rstb;
  assign ram_we    = ram_en & (kind_q == CMD_WR);
  assign ram_addr  = addr_q;
  assign ram_din   = din_q;
  assign ram_regce = 1'b1;
  assign ram_rst   = rstb;

  assign wr_ack    = ram_we ? (NREQ'(1) << id_q) : '0;
  assign rsp_valid = (tag_v[RD_LAT-1] && !rstb) ? (NREQ'(1) << tag_id[RD_LAT-1]) : '0;
  assign rsp_rdata = ram_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed and random stimulus for bram_port_arbiter against a cycle-indexed
// reference (pointer, shadow memory, due-cycle response queue) plus a BRAM model.
module tb_bram_port_arbiter;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 18;
  localparam int RD_LAT = 2;

  logic                   clk = 1'b0;
  logic                   rstb;
  logic [NREQ-1:0]        req_valid, req_we, req_ready, rsp_valid, wr_ack;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]      rsp_rdata, ram_din, ram_dout;
  logic [ADDR_W-1:0]      ram_addr;
  logic                   ram_en, ram_we, ram_regce, ram_rst;

  bram_port_arbiter #(
    .NREQ   (NREQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .wr_ack    (wr_ack),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_regce (ram_regce),
    .ram_rst   (ram_rst),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  // Block RAM with output register (two-cycle read latency).
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ram_q1, ram_q2;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_q1 <= mem[ram_addr];
    end
    if (ram_rst)        ram_q2 <= '0;
    else if (ram_regce) ram_q2 <= ram_q1;
  end
  assign ram_dout = ram_q2;

  // Reference state
  typedef struct {
    int                due;
    int                id;
    logic [DATA_W-1:0] data;
  } rsp_t;

  rsp_t              rq[$];
  logic [DATA_W-1:0] sh [0:(1<<ADDR_W)-1];
  int                ptr_m;
  int                cyc;
  logic              pend_v, pend_we;
  int                pend_id;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;

  int checks = 0;
  int errors = 0;
  int rsp1_cnt, rsp_any_cnt;

  // Per-cycle stimulus
  logic              rst_i;
  logic [NREQ-1:0]   v_i, we_i;
  logic [ADDR_W-1:0] a_i [NREQ];
  logic [DATA_W-1:0] d_i [NREQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic idle();
    rst_i = 1'b0;
    v_i   = '0;
    we_i  = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_i[i] = '0;
      d_i[i] = '0;
    end
  endtask

  task automatic cmd(input int r, input logic we, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d);
    v_i[r]  = 1'b1;
    we_i[r] = we;
    a_i[r]  = a;
    d_i[r]  = d;
  endtask

  task automatic step();
    int              gid;
    logic [NREQ-1:0] exp_g, exp_wa, exp_rv;
    logic            e_en;
    logic [DATA_W-1:0] exp_d;
    @(negedge clk);
    rstb      = rst_i;
    req_valid = v_i;
    req_we    = we_i;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W]  = a_i[i];
      req_wdata[i*DATA_W +: DATA_W] = d_i[i];
    end
    #1;
    gid   = -1;
    exp_g = '0;
    if (!rst_i) begin
      for (int k = 0; k < NREQ; k++) begin
        if (gid < 0 && v_i[(ptr_m + k) % NREQ]) gid = (ptr_m + k) % NREQ;
      end
    end
    if (gid >= 0) exp_g[gid] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_g));

    e_en = pend_v && !rst_i;
    chk("ram_en", 32'(ram_en), 32'(e_en));
    chk("ram_we", 32'(ram_we), 32'(e_en && pend_we));
    if (e_en) begin
      chk("ram_addr", 32'(ram_addr), 32'(pend_addr));
      if (pend_we) chk("ram_din", 32'(ram_din), 32'(pend_data));
    end
    exp_wa = '0;
    if (e_en && pend_we) exp_wa[pend_id] = 1'b1;
    chk("wr_ack", 32'(wr_ack), 32'(exp_wa));

    exp_rv = '0;
    exp_d  = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      if (!rst_i) begin
        exp_rv[rq[0].id] = 1'b1;
        exp_d = rq[0].data;
      end
      void'(rq.pop_front());
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv != '0) chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_d));
    if (rsp_valid[1]) rsp1_cnt++;
    if (|rsp_valid)   rsp_any_cnt++;

    if (rst_i) begin
      rq.delete();
      ptr_m  = 0;
      pend_v = 1'b0;
    end else begin
      if (e_en) begin
        if (pend_we) sh[pend_addr] = pend_data;
        else         rq.push_back('{due: cyc + RD_LAT, id: pend_id, data: sh[pend_addr]});
      end
      pend_v = (gid >= 0);
      if (gid >= 0) begin
        pend_id   = gid;
        pend_we   = we_i[gid];
        pend_addr = a_i[gid];
        pend_data = d_i[gid];
        ptr_m     = (gid + 1) % NREQ;
      end
    end
    cyc++;
  endtask

  initial begin
    rstb = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    ptr_m = 0; cyc = 0; pend_v = 1'b0; pend_we = 1'b0; pend_id = 0;
    pend_addr = '0; pend_data = '0; rsp1_cnt = 0; rsp_any_cnt = 0;
    idle();

    // Reset with every requester asserting: nothing may be granted or issued.
    rst_i = 1'b1; v_i = '1; we_i = '1;
    repeat (3) step();
    chk("rst_addr", 32'(ram_addr), 32'h0);
    chk("rst_din",  32'(ram_din),  32'h0);

    // Preload addresses 0..15 through rotating requesters.
    for (int a = 0; a < 16; a++) begin
      idle(); cmd(a % NREQ, 1'b1, ADDR_W'(a), DATA_W'(32'h100 + a * 37));
      step();
    end
    idle(); step();

    // Write 0x155 @0x010 by req 0, then read it back by req 2.
    idle(); cmd(0, 1'b1, 10'h010, 18'h155); step();
    idle(); step();
    chk("t1_wr_ack", 32'(wr_ack), 32'h1);
    idle(); cmd(2, 1'b0, 10'h010, '0); step();
    idle(); repeat (3) step();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("t1_rdata",     32'(rsp_rdata), 32'h155);
    repeat (2) step();

    // All requesters valid from ptr=0: strict rotation.
    rst_i = 1'b1; step();
    idle(); v_i = '1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NREQ; i++) a_i[i] = ADDR_W'(i + k);
      step();
      chk("rr_order", 32'(req_ready), 32'(1) << (k % NREQ));
    end
    idle(); repeat (4) step();

    // Requester 1 streams reads of 0..7 with no bubbles.
    rsp1_cnt = 0;
    for (int a = 0; a < 8; a++) begin
      idle(); cmd(1, 1'b0, ADDR_W'(a), '0); step();
    end
    idle(); repeat (4) step();
    chk("b2b_rsp_count", 32'(rsp1_cnt), 32'd8);

    // Reset inside the read latency window drops the response and clears ptr.
    rsp_any_cnt = 0;
    idle(); cmd(2, 1'b0, 10'd3, '0); step();
    idle(); step();
    rst_i = 1'b1; step();
    idle(); repeat (4) step();
    chk("rst_drop_rsp", 32'(rsp_any_cnt), 32'd0);
    idle(); v_i = '1; step();
    chk("ptr_after_rst", 32'(req_ready), 32'h1);
    idle(); repeat (3) step();

    // Write by req 3 immediately followed by read of the same address by req 0.
    idle(); cmd(3, 1'b1, 10'd5, 18'h2ABCD); step();
    idle(); cmd(0, 1'b0, 10'd5, '0); step();
    idle(); repeat (3) step();
    chk("raw_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("raw_rdata",     32'(rsp_rdata), 32'h2ABCD);
    repeat (2) step();

    // Idle cycles keep the port quiet and leave ptr where it was (1).
    idle();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("idle_en", 32'(ram_en), 32'h0);
    end
    v_i = '1; step();
    chk("ptr_hold", 32'(req_ready), 32'h2);
    idle(); repeat (3) step();

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      idle();
      rst_i = ($urandom_range(0, 39) == 0);
      v_i   = NREQ'($urandom);
      we_i  = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        a_i[i] = ADDR_W'($urandom_range(0, 15));
        d_i[i] = DATA_W'($urandom);
      end
      step();
    end
    idle(); repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
